// File: rtl/led_scan_capture.sv
// Reads back a 4-digit multiplexed 7-segment scan and rebuilds one 16-bit hex word per complete frame.
// Optional FRAME_TIMEOUT_EN: discards a partial frame after TIMEOUT idle cycles.
module led_scan_capture #(
  parameter int SETTLE         = 2,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int TIMEOUT        = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  an,
  input  logic [6:0]  seg,
  output logic [15:0] word,
  output logic        valid,
  output logic        digit_err,
  output logic        timeout
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic [3:0]      r_an_q;
  logic [6:0]      r_seg_q;
  logic            r_chg;
  logic [3:0]      r_cnt;
  logic            r_multi_d;
  logic [3:0]      r_mask;
  logic [3:0][3:0] r_slot;
  logic [15:0]     r_word;
  logic            r_valid;
  logic            r_err;
  logic            r_to;

  logic            w_one_low;
  logic            w_all_hi;
  logic            w_multi;
  logic            w_stable;
  logic [6:0]      w_pat;
  logic [3:0]      w_code;
  logic            w_dec_ok;
  logic [1:0]      w_idx;
  logic            w_cap;
  logic            w_bad;
  logic [3:0]      w_mask_nxt;
  logic [3:0][3:0] w_slot_nxt;

  assign w_all_hi  = (r_an_q == 4'b1111);
  assign w_one_low = (r_an_q == 4'b1110) || (r_an_q == 4'b1101) ||
                     (r_an_q == 4'b1011) || (r_an_q == 4'b0111);
  assign w_multi   = !w_one_low && !w_all_hi;
  assign w_stable  = (r_cnt == 4'(SETTLE));
  assign w_pat     = (SEG_ACTIVE_LOW != 0) ? r_seg_q : ~r_seg_q;

  // Table is in active-low form; w_pat is already normalised to it.
  always_comb begin
    w_code   = 4'h0;
    w_dec_ok = 1'b1;
    case (w_pat)
      7'b0000001: w_code = 4'h0;
      7'b1001111: w_code = 4'h1;
      7'b0010010: w_code = 4'h2;
      7'b0000110: w_code = 4'h3;
      7'b1001100: w_code = 4'h4;
      7'b0100100: w_code = 4'h5;
      7'b0100000: w_code = 4'h6;
      7'b0001111: w_code = 4'h7;
      7'b0000000: w_code = 4'h8;
      7'b0000100: w_code = 4'h9;
      7'b0001000: w_code = 4'hA;
      7'b1100000: w_code = 4'hB;
      7'b0110001: w_code = 4'hC;
      7'b1000010: w_code = 4'hD;
      7'b0110000: w_code = 4'hE;
      7'b0111000: w_code = 4'hF;
      default:    w_dec_ok = 1'b0;
    endcase
  end

  always_comb begin
    w_idx = 2'd0;
    case (r_an_q)
      4'b1110: w_idx = 2'd0;
      4'b1101: w_idx = 2'd1;
      4'b1011: w_idx = 2'd2;
      4'b0111: w_idx = 2'd3;
      default: w_idx = 2'd0;
    endcase
  end

  always_comb begin
    w_mask_nxt        = r_mask;
    w_mask_nxt[w_idx] = 1'b1;
    w_slot_nxt        = r_slot;
    w_slot_nxt[w_idx] = w_code;
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // A settled digit is taken the first cycle the stability counter hits SETTLE,
  // so IDLE and HOLD may capture directly when SETTLE is 1.
  always_comb begin
    w_state_nxt = r_state;
    w_cap       = 1'b0;
    w_bad       = 1'b0;
    if (w_multi) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_one_low) begin
            if (w_stable) begin
              w_cap       = w_dec_ok;
              w_bad       = !w_dec_ok;
              w_state_nxt = ST_HOLD;
            end else begin
              w_state_nxt = ST_SETTLE;
            end
          end
        end
        ST_SETTLE: begin
          if (w_all_hi) begin
            w_state_nxt = ST_IDLE;
          end else if (w_stable) begin
            w_cap       = w_dec_ok;
            w_bad       = !w_dec_ok;
            w_state_nxt = ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (r_chg) begin
            if (w_all_hi) begin
              w_state_nxt = ST_IDLE;
            end else if (w_stable) begin
              w_cap       = w_dec_ok;
              w_bad       = !w_dec_ok;
              w_state_nxt = ST_HOLD;
            end else begin
              w_state_nxt = ST_SETTLE;
            end
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

`ifdef FRAME_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] r_to_cnt;
  logic          w_to_fire;

  assign w_to_fire = !w_cap && (r_mask != 4'b0000) && (r_to_cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_to_cnt <= '0;
    end else if (w_cap || (r_mask == 4'b0000) || w_to_fire) begin
      r_to_cnt <= '0;
    end else begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end
`else
  logic w_to_fire;
  assign w_to_fire = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_an_q    <= 4'b1111;
      r_seg_q   <= 7'b0;
      r_chg     <= 1'b0;
      r_cnt     <= 4'd0;
      r_multi_d <= 1'b0;
      r_mask    <= 4'b0;
      r_slot    <= '0;
      r_word    <= 16'h0;
      r_valid   <= 1'b0;
      r_err     <= 1'b0;
      r_to      <= 1'b0;
    end else begin
      r_an_q    <= an;
      r_seg_q   <= seg;
      r_chg     <= ({an, seg} != {r_an_q, r_seg_q});
      if ({an, seg} != {r_an_q, r_seg_q})
        r_cnt <= 4'd1;
      else if (r_cnt != 4'(SETTLE))
        r_cnt <= r_cnt + 4'd1;
      r_multi_d <= w_multi;
      r_valid   <= 1'b0;
      r_err     <= w_bad || (w_multi && !r_multi_d);
      r_to      <= 1'b0;
      if (w_cap) begin
        r_slot <= w_slot_nxt;
        if (w_mask_nxt == 4'b1111) begin
          r_word  <= w_slot_nxt;
          r_valid <= 1'b1;
          r_mask  <= 4'b0;
        end else begin
          r_mask  <= w_mask_nxt;
        end
      end else if (w_to_fire) begin
        r_mask <= 4'b0;
        r_to   <= 1'b1;
      end
    end
  end

  assign word      = r_word;
  assign valid     = r_valid;
  assign digit_err = r_err;
  assign timeout   = r_to;

endmodule

// File: tb/tb_led_scan_capture.sv
// Directed bench for led_scan_capture: frame readback, settle guard, errors, overwrite, reset, timeout.
module tb_led_scan_capture;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic [15:0] word;
  logic        valid;
  logic        digit_err;
  logic        timeout;

  int n_checks = 0;
  int n_errors = 0;
  int n_valid  = 0;
  int n_err    = 0;
  int n_to     = 0;
  int cyc      = 0;
  int to_cyc   = 0;
  logic [15:0] last_word = 16'h0;

  logic [6:0] enc_tbl [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  led_scan_capture #(
    .SETTLE(2),
    .SEG_ACTIVE_LOW(1),
    .TIMEOUT(64)
  ) dut (
    .clk(clk),
    .reset(reset),
    .an(an),
    .seg(seg),
    .word(word),
    .valid(valid),
    .digit_err(digit_err),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid)     begin n_valid++; last_word = word; end
    if (digit_err) n_err++;
    if (timeout)   begin n_to++; to_cyc = cyc; end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic show(input int idx, input int code, input int hold, input int blank);
    logic [3:0] one;
    one = 4'b0001 << idx;
    an  = ~one;
    seg = enc_tbl[code];
    tick(hold);
    an  = 4'b1111;
    tick(blank);
  endtask

  int v0, e0, c0;

  initial begin
    reset = 1'b1;
    an    = 4'b1111;
    seg   = 7'b1111111;
    tick(3);
    check("rst_word", 32'(word), 32'h0);
    check("rst_valid", 32'(valid), 32'h0);
    check("rst_err", 32'(digit_err), 32'h0);
    check("rst_timeout", 32'(timeout), 32'h0);
    reset = 1'b0;
    tick(2);

    // Frame readback: an3..an0 = 0,8,2,7
    v0 = n_valid; e0 = n_err;
    show(3, 4'h0, 16, 4);
    show(2, 4'h8, 16, 4);
    show(1, 4'h2, 16, 4);
    check("frame_no_early_valid", 32'(n_valid - v0), 32'd0);
    show(0, 4'h7, 16, 4);
    check("frame_valid_cnt", 32'(n_valid - v0), 32'd1);
    check("frame_word", 32'(word), 32'h0827);
    check("frame_pulse_word", 32'(last_word), 32'h0827);
    check("frame_no_err", 32'(n_err - e0), 32'd0);

    // Settle guard: one-cycle glitch showing '2' on an3 must not be taken
    v0 = n_valid; e0 = n_err;
    an  = 4'b0111;
    seg = enc_tbl[2];
    tick(1);
    seg = enc_tbl[8];
    tick(16);
    an  = 4'b1111;
    tick(4);
    show(2, 4'h3, 16, 4);
    show(1, 4'h4, 16, 4);
    show(0, 4'h5, 16, 4);
    check("glitch_valid_cnt", 32'(n_valid - v0), 32'd1);
    check("glitch_word", 32'(word), 32'h8345);
    check("glitch_no_err", 32'(n_err - e0), 32'd0);

    // Errors: blank pattern on an2, then two anodes low together
    v0 = n_valid; e0 = n_err;
    an  = 4'b1011;
    seg = 7'b1111111;
    tick(10);
    an  = 4'b1111;
    tick(4);
    check("undecodable_err", 32'(n_err - e0), 32'd1);
    an  = 4'b0011;
    seg = enc_tbl[1];
    tick(5);
    an  = 4'b1111;
    tick(4);
    check("multi_low_err", 32'(n_err - e0), 32'd2);
    show(3, 4'h1, 16, 4);
    show(1, 4'h2, 16, 4);
    show(0, 4'h3, 16, 4);
    check("mask2_clear_no_valid", 32'(n_valid - v0), 32'd0);
    show(2, 4'hA, 16, 4);
    check("after_err_valid", 32'(n_valid - v0), 32'd1);
    check("after_err_word", 32'(word), 32'h1A23);

    // Overwrite: an0 shows 5 then 9 without leaving the anode
    v0 = n_valid; e0 = n_err;
    show(0, 4'h5, 16, 0);
    show(0, 4'h9, 16, 4);
    check("overwrite_same_slot_no_valid", 32'(n_valid - v0), 32'd0);
    show(3, 4'hB, 16, 4);
    show(2, 4'hC, 16, 4);
    show(1, 4'hD, 16, 4);
    check("overwrite_valid", 32'(n_valid - v0), 32'd1);
    check("overwrite_word", 32'(word), 32'hBCD9);
    check("overwrite_no_err", 32'(n_err - e0), 32'd0);

    // Reset mid-frame; an0 first afterwards so a stale mask would finish early
    show(3, 4'h1, 16, 4);
    show(2, 4'h2, 16, 4);
    show(1, 4'h3, 16, 4);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check("midreset_word", 32'(word), 32'h0);
    v0 = n_valid;
    show(0, 4'hC, 16, 4);
    check("midreset_mask_cleared", 32'(n_valid - v0), 32'd0);
    show(3, 4'hF, 16, 4);
    show(2, 4'hE, 16, 4);
    show(1, 4'hD, 16, 4);
    check("midreset_valid", 32'(n_valid - v0), 32'd1);
    check("midreset_word_new", 32'(word), 32'hFEDC);

    // Partial frame followed by a long idle gap
    v0 = n_valid;
    show(3, 4'h4, 16, 4);
    c0 = cyc;
    show(2, 4'h5, 1, 0);
    an = 4'b0111 & 4'b1011 | 4'b1000;
    an = 4'b1011;
    tick(15);
    an = 4'b1111;
    tick(70);
`ifdef FRAME_TIMEOUT_EN
    check("timeout_pulses", 32'(n_to), 32'd1);
    check("timeout_cycle", 32'(to_cyc - c0), 32'd67);
    check("timeout_word_kept", 32'(word), 32'hFEDC);
    show(1, 4'h6, 16, 4);
    show(0, 4'h7, 16, 4);
    check("timeout_partial_dropped", 32'(n_valid - v0), 32'd0);
    show(3, 4'h8, 16, 4);
    show(2, 4'h9, 16, 4);
    check("timeout_fresh_valid", 32'(n_valid - v0), 32'd1);
    check("timeout_fresh_word", 32'(word), 32'h8967);
`else
    check("no_timeout_pulse", 32'(n_to), 32'd0);
    check("partial_held_word", 32'(word), 32'hFEDC);
    show(1, 4'h6, 16, 4);
    show(0, 4'h7, 16, 4);
    check("partial_held_valid", 32'(n_valid - v0), 32'd1);
    check("partial_held_result", 32'(word), 32'h4567);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
